writeback_arbiter: RTL

//  Parametrised writeback stage: selects the in-order pipe result (ALU/load/PC+4/PC+imm) and

---
 rtl/writeback_arbiter_pkg.sv | 20 ++
 rtl/writeback_arbiter_if.sv | 37 +++
 rtl/writeback_arbiter_fifo.sv | 52 +++++
 rtl/writeback_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the writeback stage: the result-source select, register address,
// data word and the buffered aux write request.
package writeback_arbiter_pkg;

  typedef logic [31:0] word_st;
  typedef logic [4:0]  rf_addr_t;

  typedef enum logic [1:0] {
    RES_ALU   = 2'b00,
    RES_MEM   = 2'b01,
    RES_PC4   = 2'b10,
    RES_PCIMM = 2'b11
  } result_src_t;

  typedef struct packed {
    rf_addr_t rd;
    word_st   data;
  } wb_req_st;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of main-pipe WB inputs, aux result channels and the register-file write port.
interface writeback_arbiter_if #(
  parameter int NUM_AUX = 2
);
  import writeback_arbiter_pkg::*;

  logic                       valid_wb_i;
  rf_addr_t                   rd_wb_i;
  result_src_t                result_src_wb_i;
  word_st                     alu_result_wb_i;
  word_st                     read_data_sized_wb_i;
  word_st                     pc_next_4_wb_i;
  word_st                     pc_next_imm_wb_i;
  word_st                     result_wb_o;
  logic     [NUM_AUX-1:0]     aux_valid_i;
  rf_addr_t [NUM_AUX-1:0]     aux_rd_i;
  word_st   [NUM_AUX-1:0]     aux_data_i;
  logic     [NUM_AUX-1:0]     aux_ready_o;
  logic                       stall_o;
  logic                       aux_pending_o;
  logic                       rf_we_o;
  rf_addr_t                   rf_rd_o;
  word_st                     rf_wd_o;

  modport master (
    output valid_wb_i, rd_wb_i, result_src_wb_i, alu_result_wb_i, read_data_sized_wb_i,
           pc_next_4_wb_i, pc_next_imm_wb_i, aux_valid_i, aux_rd_i, aux_data_i,
    input  result_wb_o, aux_ready_o, stall_o, aux_pending_o, rf_we_o, rf_rd_o, rf_wd_o
  );

  modport slave (
    input  valid_wb_i, rd_wb_i, result_src_wb_i, alu_result_wb_i, read_data_sized_wb_i,
           pc_next_4_wb_i, pc_next_imm_wb_i, aux_valid_i, aux_rd_i, aux_data_i,
    output result_wb_o, aux_ready_o, stall_o, aux_pending_o, rf_we_o, rf_rd_o, rf_wd_o
  );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Small circular buffer of pending aux writes; one instance per aux channel.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push,
  input  wb_req_st push_data,
  input  logic     pop,
  output wb_req_st head,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_st         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && empty));

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: main result mux plus round-robin merge of buffered aux results onto the
// single registered RF write port, with a starvation guard that stalls the main pipe.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_AUX      = 2,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  writeback_arbiter_if.slave wb
);

  localparam int IDX_W = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [NUM_AUX-1:0] full;
  logic [NUM_AUX-1:0] empty;
  logic [NUM_AUX-1:0] push;
  logic [NUM_AUX-1:0] aux_gnt;
  wb_req_st           head [NUM_AUX];
  wb_req_st           aux_req;
  word_st             main_result;
  logic               main_req;
  logic               main_gnt;
  logic               aux_found;
  logic               aux_any;
  logic               stall;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_nxt;
  logic [SC_W-1:0]    starve_cnt;
  logic               rf_we;
  rf_addr_t           rf_rd;
  word_st             rf_wd;

  always_comb begin
    main_result = wb.alu_result_wb_i;
    case (wb.result_src_wb_i)
      RES_ALU:   main_result = wb.alu_result_wb_i;
      RES_MEM:   main_result = wb.read_data_sized_wb_i;
      RES_PC4:   main_result = wb.pc_next_4_wb_i;
      RES_PCIMM: main_result = wb.pc_next_imm_wb_i;
      default:   main_result = wb.alu_result_wb_i;
    endcase
  end

  for (genvar k = 0; k < NUM_AUX; k++) begin : g_aux
    wb_req_st push_req;
    // rd==0 results are acknowledged but never stored
    assign push[k]  = wb.aux_valid_i[k] && !full[k] && (wb.aux_rd_i[k] != '0);
    assign push_req = '{rd: wb.aux_rd_i[k], data: wb.aux_data_i[k]};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push      (push[k]),
      .push_data (push_req),
      .pop       (aux_gnt[k]),
      .head      (head[k]),
      .full      (full[k]),
      .empty     (empty[k])
    );
  end

  assign aux_any  = |(~empty);
  assign main_req = wb.valid_wb_i && (wb.rd_wb_i != '0);
  assign stall    = (starve_cnt == SC_W'(STARVE_LIMIT));
  assign main_gnt = !stall && main_req;

  // Pass 0 scans channels at/after rr_ptr, pass 1 wraps to those below it.
  always_comb begin
    aux_gnt   = '0;
    aux_req   = '0;
    aux_found = 1'b0;
    rr_nxt    = rr_ptr;
    if (!main_gnt) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int k = 0; k < NUM_AUX; k++) begin
          if (!aux_found && !empty[k] && ((pass == 0) == (k >= int'(rr_ptr)))) begin
            aux_found  = 1'b1;
            aux_gnt[k] = 1'b1;
            aux_req    = head[k];
            rr_nxt     = (k == NUM_AUX - 1) ? '0 : IDX_W'(k + 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wd      <= '0;
    end else begin
      if (aux_found) rr_ptr <= rr_nxt;
      if (aux_found || !aux_any) starve_cnt <= '0;
      else if (!stall)           starve_cnt <= starve_cnt + SC_W'(1);
      rf_we <= main_gnt || aux_found;
      if (main_gnt) begin
        rf_rd <= wb.rd_wb_i;
        rf_wd <= main_result;
      end else if (aux_found) begin
        rf_rd <= aux_req.rd;
        rf_wd <= aux_req.data;
      end
    end
  end

  assign wb.result_wb_o   = main_result;
  assign wb.aux_ready_o   = ~full;
  assign wb.stall_o       = stall;
  assign wb.aux_pending_o = aux_any;
  assign wb.rf_we_o       = rf_we;
  assign wb.rf_rd_o       = rf_rd;
  assign wb.rf_wd_o       = rf_wd;

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0({main_gnt, aux_gnt}));
  a_no_x0_write:  assert property (@(posedge clk_i) disable iff (rst_i) !(rf_we && rf_rd == '0));

endmodule
